// File: rtl/counter_datamux_evcnt.sv
// Multi-channel synchronised source mux with blanked rising-edge detection and event counters.
// Define COUNTER_DATAMUX_SAT_EN to make the counters saturate instead of wrapping.
module counter_datamux_evcnt #(
   parameter int COUNTER_NUM = 4,
   parameter int SRC_NUM     = 2,
   parameter int SEL_W       = 1,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int BLANK_CYC   = 2
)(
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [COUNTER_NUM*SRC_NUM-1:0] i_din,
   input  logic [COUNTER_NUM*SEL_W-1:0] i_mux_sel,
   input  logic [COUNTER_NUM-1:0]       i_cnt_en,
   input  logic [COUNTER_NUM-1:0]       i_cnt_clr,
   output logic [COUNTER_NUM-1:0]       o_mux_dout,
   output logic [COUNTER_NUM-1:0]       o_rise_pulse,
   output logic [COUNTER_NUM*CNT_W-1:0] o_cnt,
   output logic [COUNTER_NUM-1:0]       o_cnt_ovf
);

   localparam int NB      = COUNTER_NUM * SRC_NUM;
   localparam int SEL_N   = 2 ** SEL_W;
   localparam int BLANK_W = $clog2(BLANK_CYC + 1);
   localparam logic [SEL_W:0]       SRC_LIM  = (SEL_W + 1)'(SRC_NUM);
   localparam logic [BLANK_W-1:0]   BLANK_LD = BLANK_W'(BLANK_CYC);

   logic [SYNC_STAGES-1:0][NB-1:0] sync_q;
   logic [SEL_W-1:0]               sel_q [COUNTER_NUM];
   logic [BLANK_W-1:0]             blank [COUNTER_NUM];
   logic [COUNTER_NUM-1:0]         prev_lvl;
   logic [SEL_N-1:0]               cand  [COUNTER_NUM];
   logic [COUNTER_NUM-1:0]         rise;
   logic [COUNTER_NUM-1:0]         sel_load;

   // Synchronised sources of each channel, padded so every select code indexes a defined bit.
   always_comb begin
      for (int unsigned c = 0; c < COUNTER_NUM; c++) begin
         cand[c] = '0;
         for (int unsigned s = 0; s < SRC_NUM; s++) begin
            cand[c][s] = sync_q[SYNC_STAGES-1][c*SRC_NUM + s];
         end
         rise[c]     = o_mux_dout[c] & ~prev_lvl[c] & (blank[c] == '0);
         sel_load[c] = (i_mux_sel[c*SEL_W +: SEL_W] != sel_q[c]) &&
                       ({1'b0, i_mux_sel[c*SEL_W +: SEL_W]} < SRC_LIM);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q       <= '0;
         prev_lvl     <= '0;
         o_mux_dout   <= '0;
         o_rise_pulse <= '0;
         o_cnt        <= '0;
         o_cnt_ovf    <= '0;
         for (int unsigned c = 0; c < COUNTER_NUM; c++) begin
            sel_q[c] <= '0;
            blank[c] <= '0;
         end
      end else begin
         sync_q[0] <= i_din;
         for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         prev_lvl     <= o_mux_dout;
         o_rise_pulse <= rise;
         for (int unsigned c = 0; c < COUNTER_NUM; c++) begin
            o_mux_dout[c] <= cand[c][sel_q[c]];
            if (sel_load[c]) begin
               sel_q[c] <= i_mux_sel[c*SEL_W +: SEL_W];
               blank[c] <= BLANK_LD;
            end else if (blank[c] != '0) begin
               blank[c] <= blank[c] - BLANK_W'(1);
            end
            // Clear outranks a coincident accepted rise; that rise is dropped.
            if (i_cnt_clr[c]) begin
               o_cnt[c*CNT_W +: CNT_W] <= '0;
               o_cnt_ovf[c]            <= 1'b0;
            end else if (rise[c] && i_cnt_en[c]) begin
               if (o_cnt[c*CNT_W +: CNT_W] == '1) begin
`ifndef COUNTER_DATAMUX_SAT_EN
                  o_cnt[c*CNT_W +: CNT_W] <= '0;
`endif
                  o_cnt_ovf[c] <= 1'b1;
               end else begin
                  o_cnt[c*CNT_W +: CNT_W] <= o_cnt[c*CNT_W +: CNT_W] + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule
